// File: rtl/mips5_pkg.sv
// Shared constants for the 5-stage MIPS core: default widths, ALU opcodes
// and the hard-wired zero register.
package mips5_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int SHAMT_W_DEF = 6;

    // ALU opcodes; ALU_NOP makes the ALU drive 0, which is what a bubble wants
    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one ALU operand. The youngest producer
// (EX/MEM) wins over MEM/WB, which wins over the value latched from the
// register file. Register 0 is never forwarded.
module fwd_mux
    import mips5_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [DATA_W-1:0] reg_val,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic              exmem_reg_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_reg_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_res,
    output logic [DATA_W-1:0] opnd
);

    logic addr_nonzero;
    logic exmem_hit;
    logic memwb_hit;

    assign addr_nonzero = (reg_addr != '0);
    assign exmem_hit    = exmem_reg_wr && (exmem_rd == reg_addr) && addr_nonzero;
    assign memwb_hit    = memwb_reg_wr && (memwb_rd == reg_addr) && addr_nonzero;

    // Priority select: EX/MEM, then MEM/WB, then the registered operand
    always_comb begin
        opnd = reg_val;
        if (exmem_hit) begin
            opnd = exmem_res;
        end else if (memwb_hit) begin
            opnd = memwb_res;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core, feeding the ALU.
// Latches decoded operands/control, detects hazards and inserts bubbles,
// honours flush and ex_hold, and forwards EX/MEM and MEM/WB results.
// Build option: define MIPS5_FWD_EN to enable operand forwarding; without
// it operands come straight from the register and RAW hazards on the EX
// and EX/MEM producers stall ID instead.
module id_ex_stage
    import mips5_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_data1,
    input  logic [DATA_W-1:0]  id_data2,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic [3:0]         id_alu_ctrl,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic               id_reg_wr,
    input  logic               id_mem_rd,
    input  logic               flush,
    input  logic               ex_hold,
    input  logic               exmem_reg_wr,
    input  logic [REG_AW-1:0]  exmem_rd,
    input  logic [DATA_W-1:0]  exmem_res,
    input  logic               memwb_reg_wr,
    input  logic [REG_AW-1:0]  memwb_rd,
    input  logic [DATA_W-1:0]  memwb_res,
    output logic               id_stall,
    output logic               ex_valid,
    output logic               ex_reg_wr,
    output logic               ex_mem_rd,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [3:0]         ex_alu_ctrl,
    output logic [SHAMT_W-1:0] ex_shamt,
    output logic [DATA_W-1:0]  ex_data1,
    output logic [DATA_W-1:0]  ex_data2
);

`ifdef MIPS5_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic               valid_reg;
    logic               reg_wr_reg;
    logic               mem_rd_reg;
    logic [REG_AW-1:0]  rd_reg;
    logic [3:0]         alu_ctrl_reg;
    logic [SHAMT_W-1:0] shamt_reg;

    // Index 0 is the rs/data1 operand, index 1 the rt/data2 operand
    logic [REG_AW-1:0]  id_src   [2];
    logic [DATA_W-1:0]  id_opnd  [2];
    logic [REG_AW-1:0]  src_reg  [2];
    logic [DATA_W-1:0]  opnd_reg [2];
    logic [DATA_W-1:0]  fwd_data [2];

    logic load_use;
    logic rs_dep;
    logic rt_dep;
    logic bubble;

    assign id_src[0]  = id_rs;
    assign id_src[1]  = id_rt;
    assign id_opnd[0] = id_data1;
    assign id_opnd[1] = id_data2;

    // A load in EX cannot forward in time: its consumer in ID must wait
    assign load_use = id_valid && valid_reg && mem_rd_reg && (rd_reg != '0) &&
                      ((rd_reg == id_rs) || (rd_reg == id_rt));

    // Without forwarding, any pending write by EX or EX/MEM blocks the reader
    assign rs_dep = (id_rs != '0) &&
                    ((valid_reg && reg_wr_reg && (rd_reg == id_rs)) ||
                     (exmem_reg_wr && (exmem_rd == id_rs)));
    assign rt_dep = (id_rt != '0) &&
                    ((valid_reg && reg_wr_reg && (rd_reg == id_rt)) ||
                     (exmem_reg_wr && (exmem_rd == id_rt)));

    assign id_stall = !ex_hold &&
                      (load_use || (!FWD_EN && id_valid && (rs_dep || rt_dep)));

    // id_stall is already masked by ex_hold, so flush > ex_hold > id_stall holds
    assign bubble = rst || flush || id_stall;

    // Control fields: clear on reset/bubble, freeze on hold, else take ID
    always_ff @(posedge clk) begin
        if (bubble) begin
            valid_reg    <= 1'b0;
            reg_wr_reg   <= 1'b0;
            mem_rd_reg   <= 1'b0;
            rd_reg       <= '0;
            alu_ctrl_reg <= ALU_NOP;
            shamt_reg    <= '0;
        end else if (!ex_hold) begin
            valid_reg    <= id_valid;
            reg_wr_reg   <= id_reg_wr;
            mem_rd_reg   <= id_mem_rd;
            rd_reg       <= id_rd;
            alu_ctrl_reg <= id_alu_ctrl;
            shamt_reg    <= id_shamt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            // Operand register; on hold it re-captures the forwarded value so
            // the result survives its producer leaving MEM/WB
            always_ff @(posedge clk) begin
                if (bubble) begin
                    src_reg[gi]  <= '0;
                    opnd_reg[gi] <= '0;
                end else if (ex_hold) begin
                    opnd_reg[gi] <= fwd_data[gi];
                end else begin
                    src_reg[gi]  <= id_src[gi];
                    opnd_reg[gi] <= id_opnd[gi];
                end
            end

            fwd_mux #(
                .DATA_W (DATA_W),
                .REG_AW (REG_AW)
            ) u_fwd (
                .reg_val      (opnd_reg[gi]),
                .reg_addr     (src_reg[gi]),
                .exmem_reg_wr (exmem_reg_wr && FWD_EN),
                .exmem_rd     (exmem_rd),
                .exmem_res    (exmem_res),
                .memwb_reg_wr (memwb_reg_wr && FWD_EN),
                .memwb_rd     (memwb_rd),
                .memwb_res    (memwb_res),
                .opnd         (fwd_data[gi])
            );
        end
    endgenerate

    assign ex_valid    = valid_reg;
    assign ex_reg_wr   = reg_wr_reg;
    assign ex_mem_rd   = mem_rd_reg;
    assign ex_rd       = rd_reg;
    assign ex_alu_ctrl = alu_ctrl_reg;
    assign ex_shamt    = shamt_reg;
    assign ex_data1    = fwd_data[0];
    assign ex_data2    = fwd_data[1];

endmodule
